// File: rtl/mem_access_unit.sv
// Load/store stage: routes ALU-addressed accesses to data BRAM or MMIO,
// applies lane masking and load extension, returns a one-cycle response.
module mem_access_unit #(
  parameter int          ADDR_W     = 14,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FC00,
  parameter int          IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy,
  output logic              dm_en,
  output logic [3:0]        dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  output logic [9:0]        io_addr,
  output logic              io_re,
  output logic              io_we,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ready
);
  localparam int CW = $clog2(IO_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, MEM_RD, IO_WAIT, RESP} state_t;

  state_t        state, state_n;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic [9:0]    ioa_q;
  logic [31:0]   iow_q;
  logic          iowr_q;
  logic [CW-1:0] cnt;

  logic          accept, is_io, f3_ok, is_h, is_w, misal, acc, bad;
  logic          timeout, upd, err_n;
  logic [31:0]   rdata_n, lane, ld_ext;
  logic [3:0]    we_mask;

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid & req_ready & ~rst;

  assign is_io   = (addr[31:10] == IO_BASE[31:10]);
  assign f3_ok   = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign is_h    = (funct3[1:0] == 2'b01);
  assign is_w    = (funct3 == 3'b010);
  assign misal   = (is_h & addr[0]) | (is_w & (addr[1:0] != 2'b00));
  assign acc     = mem_read | mem_write;
  // funct3 only matters once an access is actually requested
  assign bad     = (mem_read & mem_write)
                 | (acc & (~f3_ok | (mem_write & funct3[2]) | misal
                 | (is_io & ~is_w)));
  assign timeout = (cnt == CW'(IO_TIMEOUT));

  assign dm_addr  = addr[ADDR_W+1:2];
  assign io_addr  = ioa_q;
  assign io_wdata = iow_q;

  always_comb begin
    we_mask  = 4'b1111;
    dm_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        we_mask  = 4'b0001 << addr[1:0];
        dm_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        we_mask  = 4'b0011 << addr[1:0];
        dm_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = dm_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_ext = lane;
    case (f3_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ld_ext = {24'd0, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ld_ext = {16'd0, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  always_comb begin
    state_n = state;
    dm_en   = 1'b0;
    dm_we   = 4'b0000;
    io_re   = 1'b0;
    io_we   = 1'b0;
    upd     = 1'b0;
    rdata_n = 32'd0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad) begin
            state_n = RESP;
            upd     = 1'b1;
            err_n   = 1'b1;
          end else if (!acc) begin
            state_n = RESP;
            upd     = 1'b1;
          end else if (is_io) begin
            state_n = IO_WAIT;
          end else if (mem_write) begin
            dm_en   = 1'b1;
            dm_we   = we_mask;
            state_n = RESP;
            upd     = 1'b1;
          end else begin
            dm_en   = 1'b1;
            state_n = MEM_RD;
          end
        end
      end
      MEM_RD: begin
        upd     = 1'b1;
        rdata_n = ld_ext;
        state_n = RESP;
      end
      IO_WAIT: begin
        if (timeout) begin
          state_n = RESP;
          upd     = 1'b1;
          err_n   = 1'b1;
        end else begin
          io_re = ~iowr_q;
          io_we = iowr_q;
          if (io_ready) begin
            state_n = RESP;
            upd     = 1'b1;
            rdata_n = iowr_q ? 32'd0 : io_rdata;
          end
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      off_q  <= '0;
      f3_q   <= '0;
      ioa_q  <= '0;
      iow_q  <= '0;
      iowr_q <= 1'b0;
      cnt    <= '0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        off_q  <= addr[1:0];
        f3_q   <= funct3;
        ioa_q  <= addr[9:0];
        iow_q  <= wdata;
        iowr_q <= mem_write;
        cnt    <= '0;
      end else if (state == IO_WAIT && !timeout) begin
        cnt <= cnt + 1'b1;
      end
      if (upd) begin
        rdata <= rdata_n;
        err   <= err_n;
      end
    end
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store stage directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as the store data. It routes each access to the synchronous data BRAM (1-cycle read latency) or to the MMIO window, applies byte-lane masking and load sign/zero extension, and returns a single-cycle response to writeback. The pipeline stalls on `busy`.

Parameters:
ADDR_W, 14, word-address bits of data BRAM (64 KiB); higher address bits ignored (aliasing)
IO_BASE, 32'hFFFF_FC00, base of 1 KiB MMIO window; match on addr[31:10]==IO_BASE[31:10]
IO_TIMEOUT, 255, max cycles to wait for io_ready before flagging err

Ports:
clk  in  1  system clock
rst  in  1  reset
req_valid  in  1  access request
req_ready  out  1  high only in IDLE
mem_read  in  1  load request
mem_write  in  1  store request
funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  effective address (ALU result)
wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle response strobe
rdata  out  32  extended load data; 0 for store/err
err  out  1  qualified by resp_valid
busy  out  1  state!=IDLE
dm_en  out  1  BRAM enable
dm_we  out  4  byte write enables
dm_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
dm_wdata  out  32  lane-replicated store data
dm_rdata  in  32  BRAM data, valid cycle after dm_en
io_addr  out  10  addr[9:0]
io_re  out  1  MMIO read strobe
io_we  out  1  MMIO write strobe
io_wdata  out  32  raw wdata
io_rdata  in  32  MMIO read data
io_ready  in  1  MMIO completion

Behaviour:
- Reset: one clock `clk`; `rst` is asynchronous, active-high.
  - Forces IDLE immediately, including mid-operation; any pending access is abandoned.
  - All registered outputs go to 0. io_re/io_we deassert immediately.
- FSM states: IDLE, MEM_RD, IO_WAIT, RESP. Accept = req_valid & req_ready.
- Error conditions at accept:
  - mem_read & mem_write both set.
  - funct3 not in {000,001,010,100,101}.
  - Stores with funct3 100/101.
  - Halfword with addr[0]=1, or word with addr[1:0]!=0.
  - MMIO access other than LW/SW.
- On error at accept: no dm/io strobe; go to RESP with err=1, rdata=0.
- Neither mem_read nor mem_write set: no access; go to RESP with err=0, rdata=0.
- Memory store: dm_en=1 and dm_we driven combinationally in the accept cycle; go to RESP. Response 1 cycle after accept.
  - SB: dm_we=0001<<addr[1:0], dm_wdata={4{wdata[7:0]}}.
  - SH: dm_we=0011<<addr[1:0], dm_wdata={2{wdata[15:0]}}.
  - SW: dm_we=1111, dm_wdata=wdata.
- Memory load:
  - Accept cycle: dm_en=1, dm_we=0; latch addr[1:0] and funct3.
  - MEM_RD: select lane from dm_rdata using the latched offset; extend per latched funct3 into rdata; go to RESP.
  - Response 2 cycles after accept.
- MMIO:
  - Latch addr and wdata at accept; enter IO_WAIT.
  - In IO_WAIT, io_re (load) or io_we (store) is held high every cycle until the cycle io_ready=1. In that cycle, capture io_rdata (loads) and go to RESP.
  - A cycle counter starts at 0 on entry. If it reaches IO_TIMEOUT without io_ready, drop strobes, go to RESP with err=1, rdata=0.
  - io_ready outside IO_WAIT is ignored.
- RESP: resp_valid=1 for exactly one cycle with rdata/err registered, then IDLE. rdata holds its value until the next response.
- Throughput: at most one request per 2 cycles. req_valid while busy is not accepted; the upstream stage holds it.
- dm_en, dm_we, io_re and io_we are never active in the same cycle as err responses, or outside their specified cycles.

Test Plan:
- BRAM word at 0x10 = 0x8077_F0AB:
  - LB 0x11 -> rdata 0xFFFF_FFF0, 2 cycles after accept.
  - LBU 0x13 -> 0x0000_0080.
  - LH 0x12 -> 0xFFFF_8077.
  - LHU 0x10 -> 0x0000_F0AB.
- SB addr 0x22, wdata 0x0000_00CD -> accept cycle dm_we=0100, dm_wdata=0xCDCD_CDCD, dm_addr=8; resp_valid next cycle, err=0.
- LW at 0x16 -> no dm_en, resp_valid next cycle, err=1, rdata=0. SH at 0x21 -> same.
- SW to 0xFFFF_FC40, wdata 0x55, io_ready after 3 cycles -> io_we high 3 cycles, io_addr=0x040, resp_valid the cycle after io_ready.
  - Repeat with io_ready never asserted -> err=1 after IO_TIMEOUT cycles.
- rst asserted in MEM_RD and again in IO_WAIT -> same-cycle io_re=0, busy=0, req_ready=1; no resp_valid follows.
- Back-to-back loads with req_valid held high -> second accepted the cycle after the first response; req_ready low while busy.
